// File: rtl/swi_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module : swi_debounce_pkg
// Brief  : Shared defaults, event FSM state encoding and counter sizing helper
//          for the switch debouncer.
// Rev    : 1.0  initial release
// ============================================================================
package swi_debounce_pkg;

    localparam int unsigned DEF_NBITS     = 8;
    localparam int unsigned DEF_DB_CYCLES = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } evt_state_e;

    // Counter only ever holds 0..DB_CYCLES-1.
    function automatic int unsigned cnt_width(input int unsigned db);
        return (db <= 2) ? 1 : $clog2(db);
    endfunction

endpackage
`default_nettype wire

// File: rtl/swi_debounce_if.sv
`default_nettype none
// ============================================================================
// Module : swi_debounce_if
// Brief  : Switch input, debounced outputs and change-event handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface swi_debounce_if
    import swi_debounce_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS
);
    logic [NBITS-1:0] swi_raw;
    logic [NBITS-1:0] swi_stable;
    logic [NBITS-1:0] swi_rise;
    logic [NBITS-1:0] swi_fall;
    logic             evt_valid;
    logic [NBITS-1:0] evt_code;
    logic             evt_ack;
    logic             evt_overrun;

    // Debouncer side.
    modport slave (
        input  swi_raw,
        input  evt_ack,
        output swi_stable,
        output swi_rise,
        output swi_fall,
        output evt_valid,
        output evt_code,
        output evt_overrun
    );

    // Board / consumer side.
    modport master (
        output swi_raw,
        output evt_ack,
        input  swi_stable,
        input  swi_rise,
        input  swi_fall,
        input  evt_valid,
        input  evt_code,
        input  evt_overrun
    );
endinterface
`default_nettype wire

// File: rtl/swi_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module : debounce_bit
// Brief  : One switch: 2-flop synchronizer, agreement counter, stable flop and
//          registered edge pulses. Fall pulse built only with
//          SWI_DEBOUNCE_FALL_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
module debounce_bit
    import swi_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  wire logic clk_2,
    input  wire logic reset,
    input  wire logic raw,
    output logic      stable,
    output logic      stable_next,
    output logic      chg,
    output logic      rise,
    output logic      fall
);
    localparam int unsigned   CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_hit;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        w_hit    = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                w_hit    = 1'b1;
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = w_hit & sync2_q;
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

`ifdef SWI_DEBOUNCE_FALL_EN
    logic fall_q, fall_d;

    always_comb begin
        fall_d = w_hit & ~sync2_q;
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
`else
    assign fall = 1'b0;
`endif

    assign stable      = stable_q;
    assign stable_next = stable_d;
    assign chg         = w_hit;
    assign rise        = rise_q;

endmodule
`default_nettype wire

// File: rtl/swi_debounce.sv
`default_nettype none
// ============================================================================
// Module : swi_debounce
// Brief  : NBITS-wide switch debouncer with a single-entry change-event FSM.
//          Define SWI_DEBOUNCE_FALL_EN to build the swi_fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
module swi_debounce
    import swi_debounce_pkg::*;
#(
    parameter int unsigned NBITS     = DEF_NBITS,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  wire logic     clk_2,
    input  wire logic     reset,
    swi_debounce_if.slave bus
);
    logic [NBITS-1:0] w_stable;
    logic [NBITS-1:0] w_stable_next;
    logic [NBITS-1:0] w_chg;
    logic [NBITS-1:0] w_rise;
    logic [NBITS-1:0] w_fall;
    logic             w_any_chg;

    for (genvar i = 0; i < int'(NBITS); i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_bit (
            .clk_2       (clk_2),
            .reset       (reset),
            .raw         (bus.swi_raw[i]),
            .stable      (w_stable[i]),
            .stable_next (w_stable_next[i]),
            .chg         (w_chg[i]),
            .rise        (w_rise[i]),
            .fall        (w_fall[i])
        );
    end

    assign w_any_chg = |w_chg;

    evt_state_e       state_q, state_d;
    logic [NBITS-1:0] code_q, code_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (w_any_chg) begin
                    state_d = PEND;
                    code_d  = w_stable_next;
                end
            end
            PEND: begin
                // A change arriving with the ack replaces the consumed event.
                if (w_any_chg) begin
                    if (bus.evt_ack) begin
                        code_d = w_stable_next;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (bus.evt_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.swi_stable  = w_stable;
    assign bus.swi_rise    = w_rise;
    assign bus.swi_fall    = w_fall;
    assign bus.evt_valid   = (state_q == PEND);
    assign bus.evt_code    = code_q;
    assign bus.evt_overrun = ovr_q;

endmodule
`default_nettype wire
